// File: rtl/fp_pkg.sv
// fp_pkg: shared widths and FSM state type for the FP operand alignment stage.
//   FP_EXP_W   exponent width default
//   FP_MAN_W   stored fraction width default
//   FP_ALN_W   aligned mantissa width {hidden, frac, G, R, S}
//   FP_STEP    maximum right-shift applied per SHIFT cycle
package fp_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_ALN_W = FP_MAN_W + 4;
  localparam int FP_STEP  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMP   = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/fp_sticky_shift.sv
// fp_sticky_shift: combinational logical right shift by 0..4 places. Every bit
// shifted out past bit 0 is ORed back into bit 0 of the result (sticky fold).
//   din_i   W   value to shift
//   amt_i   3   shift amount, 0..4
//   dout_o  W   shifted value with sticky in bit 0
module fp_sticky_shift #(
  parameter int W = 27
) (
  input  logic [W-1:0] din_i,
  input  logic [2:0]   amt_i,
  output logic [W-1:0] dout_o
);

  logic [W-1:0] mask;
  logic [W-1:0] shifted;
  logic         sticky;

  always_comb begin
    mask    = (W'(1) << amt_i) - W'(1);
    shifted = din_i >> amt_i;
    sticky  = |(din_i & mask);
    dout_o  = {shifted[W-1:1], shifted[0] | sticky};
  end

endmodule

// File: rtl/fp_align_stage.sv
// fp_align_stage: exponent compare and mantissa alignment ahead of an FP adder.
// Captures an operand pair, picks the larger-magnitude operand, and right-shifts
// the smaller mantissa (up to 4 places per cycle, with sticky) to the common
// exponent. Results are held until the downstream adder takes them.
//   clk, rst_n             clock, async active-low reset
//   in_valid / in_ready    operand handshake (ready only when idle)
//   in_a, in_b             IEEE-754 operands {sign, exp, frac}
//   out_valid / out_ready  result handshake
//   out_exp                common (larger) effective exponent
//   out_man_l, out_man_s   larger / aligned smaller mantissa {hidden, frac, G, R, S}
//   out_sign_l             sign of the larger operand
//   out_eff_sub            sign_a ^ sign_b
//   out_special            an operand exponent is all-ones
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// CMP   | compare exponents, load larger operand, choose shift path
// SHIFT | shift smaller mantissa right by up to 4 per cycle
// HOLD  | result valid, waiting for out_ready
module fp_align_stage
  import fp_pkg::*;
#(
  parameter  int EXP_W = FP_EXP_W,
  parameter  int MAN_W = FP_MAN_W,
  localparam int ALN_W = MAN_W + 4,
  localparam int OP_W  = EXP_W + MAN_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] out_exp,
  output logic [ALN_W-1:0] out_man_l,
  output logic [ALN_W-1:0] out_man_s,
  output logic             out_sign_l,
  output logic             out_eff_sub,
  output logic             out_special
);

  localparam int CNT_W = $clog2(ALN_W);

  state_t             state_q, state_d;
  logic [OP_W-1:0]    a_q, a_d, b_q, b_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic [ALN_W-1:0]   man_l_q, man_l_d, man_s_q, man_s_d;
  logic               sign_l_q, sign_l_d, eff_sub_q, eff_sub_d, special_q, special_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [EXP_W-1:0]   ea_raw, eb_raw, ea_eff, eb_eff, exp_l, exp_s, diff;
  logic [ALN_W-1:0]   ma, mb, man_l, man_s_raw, man_s_shifted;
  logic               a_is_l, special, far;
  logic [2:0]         step;

  // Decode of the captured operands; a zero exponent counts as exponent 1.
  assign ea_raw = a_q[OP_W-2 -: EXP_W];
  assign eb_raw = b_q[OP_W-2 -: EXP_W];
  assign ea_eff = (ea_raw == '0) ? EXP_W'(1) : ea_raw;
  assign eb_eff = (eb_raw == '0) ? EXP_W'(1) : eb_raw;
  assign ma     = {ea_raw != '0, a_q[MAN_W-1:0], 3'b000};
  assign mb     = {eb_raw != '0, b_q[MAN_W-1:0], 3'b000};

  // Ties on exponent fall to mantissa magnitude, full ties to operand a.
  assign a_is_l    = (ea_eff > eb_eff) || ((ea_eff == eb_eff) && (ma >= mb));
  assign exp_l     = a_is_l ? ea_eff : eb_eff;
  assign exp_s     = a_is_l ? eb_eff : ea_eff;
  assign man_l     = a_is_l ? ma : mb;
  assign man_s_raw = a_is_l ? mb : ma;
  assign diff      = exp_l - exp_s;
  assign special   = (&ea_raw) | (&eb_raw);
  assign far       = int'(diff) >= ALN_W;

  assign step = (cnt_q > CNT_W'(FP_STEP)) ? 3'(FP_STEP) : cnt_q[2:0];

  fp_sticky_shift #(.W(ALN_W)) u_shift (
    .din_i  (man_s_q),
    .amt_i  (step),
    .dout_o (man_s_shifted)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    exp_d     = exp_q;
    man_l_d   = man_l_q;
    man_s_d   = man_s_q;
    sign_l_d  = sign_l_q;
    eff_sub_d = eff_sub_q;
    special_d = special_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          state_d = CMP;
        end
      end
      CMP: begin
        exp_d     = exp_l;
        man_l_d   = man_l;
        sign_l_d  = a_is_l ? a_q[OP_W-1] : b_q[OP_W-1];
        eff_sub_d = a_q[OP_W-1] ^ b_q[OP_W-1];
        special_d = special;
        cnt_d     = '0;
        if (special || (diff == '0)) begin
          man_s_d = man_s_raw;
          state_d = HOLD;
        end else if (far) begin
          // Everything would be shifted out; only the sticky survives.
          man_s_d = {{(ALN_W-1){1'b0}}, |man_s_raw};
          state_d = HOLD;
        end else begin
          man_s_d = man_s_raw;
          cnt_d   = CNT_W'(diff);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        man_s_d = man_s_shifted;
        cnt_d   = cnt_q - CNT_W'(step);
        if (cnt_q == CNT_W'(step)) state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      exp_q     <= '0;
      man_l_q   <= '0;
      man_s_q   <= '0;
      sign_l_q  <= 1'b0;
      eff_sub_q <= 1'b0;
      special_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      exp_q     <= exp_d;
      man_l_q   <= man_l_d;
      man_s_q   <= man_s_d;
      sign_l_q  <= sign_l_d;
      eff_sub_q <= eff_sub_d;
      special_q <= special_d;
      cnt_q     <= cnt_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == HOLD);
  assign out_exp     = exp_q;
  assign out_man_l   = man_l_q;
  assign out_man_s   = man_s_q;
  assign out_sign_l  = sign_l_q;
  assign out_eff_sub = eff_sub_q;
  assign out_special = special_q;

endmodule

// File: tb/tb_fp_align_stage.sv
// Testbench for fp_align_stage: directed literal cases plus randomized traffic
// checked every cycle against a behavioural alignment model.
module tb_fp_align_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0, in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_exp;
  logic [26:0] out_man_l, out_man_s;
  logic        out_sign_l, out_eff_sub, out_special;

  always #5 clk = ~clk;

  fp_align_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_exp(out_exp), .out_man_l(out_man_l), .out_man_s(out_man_s),
    .out_sign_l(out_sign_l), .out_eff_sub(out_eff_sub), .out_special(out_special)
  );

  typedef struct {
    logic [7:0]  e;
    logic [26:0] ml;
    logic [26:0] ms;
    logic        sl;
    logic        es;
    logic        sp;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   rdy_mode = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Alignment from first principles: a single exact shift with sticky.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t m;
    int ea, eb, d;
    logic [26:0] ma, mb, ms;
    logic al;
    ea = (a[30:23] == 8'd0) ? 1 : int'(a[30:23]);
    eb = (b[30:23] == 8'd0) ? 1 : int'(b[30:23]);
    ma = {a[30:23] != 8'd0, a[22:0], 3'b000};
    mb = {b[30:23] != 8'd0, b[22:0], 3'b000};
    al = (ea > eb) || (ea == eb && ma >= mb);
    m.e  = al ? 8'(ea) : 8'(eb);
    d    = al ? ea - eb : eb - ea;
    m.ml = al ? ma : mb;
    ms   = al ? mb : ma;
    m.sl = al ? a[31] : b[31];
    m.es = a[31] ^ b[31];
    m.sp = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
    if (m.sp || d == 0) begin
      m.ms = ms; m.lat = 2;
    end else if (d >= 27) begin
      m.ms = (ms != 0) ? 27'd1 : 27'd0; m.lat = 2;
    end else begin
      m.ms  = (ms >> d) | (((ms & ((27'd1 << d) - 27'd1)) != 0) ? 27'd1 : 27'd0);
      m.lat = (d + 3) / 4 + 2;
    end
    m.acc = 0;
    return m;
  endfunction

  function automatic logic [31:0] rand_op();
    int sel;
    logic [7:0] e;
    logic [22:0] f;
    sel = $urandom_range(7);
    if (sel < 5)       e = 8'($urandom_range(134, 100));
    else if (sel == 5) e = 8'd0;
    else if (sel == 6) e = 8'hFF;
    else               e = 8'($urandom);
    f = ($urandom_range(3) == 0) ? 23'd0 : 23'($urandom);
    return {1'($urandom), e, f};
  endfunction

  // Accept monitor: an operand pair enters the model when the DUT takes it.
  initial begin
    exp_t m;
    forever begin
      @(posedge clk);
      if (rst_n && in_valid && in_ready) begin
        m = model(in_a, in_b);
        m.acc = cyc + 1;
        q.push_back(m);
      end
      cyc++;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'($urandom);
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Compare process: handshake timing and data, every cycle.
  initial begin
    logic exp_valid;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        exp_valid = (q.size() > 0) && (cyc - q[0].acc + 1 >= q[0].lat);
        check("in_ready", in_ready, q.size() == 0);
        check("out_valid", out_valid, exp_valid);
        if (exp_valid) begin
          check("out_exp", out_exp, q[0].e);
          check("out_man_l", out_man_l, q[0].ml);
          check("out_man_s", out_man_s, q[0].ms);
          check("out_sign_l", out_sign_l, q[0].sl);
          check("out_eff_sub", out_eff_sub, q[0].es);
          check("out_special", out_special, q[0].sp);
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || !in_ready) && n < 200) begin
      @(posedge clk); #2; n++;
    end
    check("drain_timeout", n >= 200, 1'b0);
  endtask

  task automatic dir(input logic [31:0] a, input logic [31:0] b, input logic [7:0] e,
                     input logic [26:0] ml, input logic [26:0] ms,
                     input logic sl, input logic es, input logic sp, input int lat);
    exp_t m;
    int l;
    m = model(a, b);
    check("model_exp", m.e, e);
    check("model_man", {m.ml, m.ms}, {ml, ms});
    check("model_flags", {m.sl, m.es, m.sp}, {sl, es, sp});
    check("model_lat", m.lat, lat);
    rdy_mode = 2;
    @(posedge clk); #2;
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
    l = 1;
    while (!out_valid && l < 40) begin
      @(posedge clk); l++; #2;
    end
    check("dir_latency", l, lat);
    check("dir_exp", out_exp, e);
    check("dir_man_l", out_man_l, ml);
    check("dir_man_s", out_man_s, ms);
    check("dir_flags", {out_sign_l, out_eff_sub, out_special}, {sl, es, sp});
    repeat (5) @(posedge clk);
    #2;
    check("hold_man_s", out_man_s, ms);
    check("hold_in_ready", in_ready, 1'b0);
    check("hold_out_valid", out_valid, 1'b1);
    rdy_mode = 1;
    drain();
  endtask

  initial begin
    #3;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_data", {out_exp, out_man_l, out_man_s}, 62'd0);
    check("rst_flags", {out_sign_l, out_eff_sub, out_special}, 3'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    dir(32'h3F800000, 32'h3F800000, 8'h7F, 27'h4000000, 27'h4000000, 1'b0, 1'b0, 1'b0, 2);
    dir(32'h3F800000, 32'h40400000, 8'h80, 27'h6000000, 27'h2000000, 1'b0, 1'b0, 1'b0, 3);
    dir(32'h42000000, 32'hBF800001, 8'h84, 27'h4000000, 27'h0200001, 1'b0, 1'b1, 1'b0, 4);
    dir(32'h4E800000, 32'h3F800000, 8'h9D, 27'h4000000, 27'h0000001, 1'b0, 1'b0, 1'b0, 2);
    dir(32'h7F800000, 32'h3F800000, 8'hFF, 27'h4000000, 27'h4000000, 1'b0, 1'b0, 1'b1, 2);
    dir(32'h3F800000, 32'hC1000000, 8'h82, 27'h4000000, 27'h0800000, 1'b1, 1'b1, 1'b0, 3);

    // Reset in the middle of a d=20 shift sequence.
    rdy_mode = 1;
    @(posedge clk); #2;
    in_a = 32'h49800000; in_b = 32'h3F800000; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_data", {out_exp, out_man_s}, 35'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    in_a = 32'h3F800000; in_b = 32'h40400000; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    check("first_accept", in_ready, 1'b0);
    drain();

    rdy_mode = 0;
    repeat (3000) begin
      @(posedge clk); #2;
      in_valid = ($urandom_range(2) != 0);
      in_a = rand_op();
      in_b = rand_op();
    end
    in_valid = 1'b0;
    rdy_mode = 1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
